mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer for the single-port 256x32 data memory. Accepts read/write requests from a fetch port (port 0) and a load/store port (port 1), grants them round-robin, drives the memory's write_enable/address/write_data pins, and returns read data with a done pulse. Sits between the fetch/execute stages and the memory; it is the only driver of the memory inputs.

## Interface
- DEPTH, 256: number of memory words; legal addresses are 0..DEPTH-1.
- DATA_W, 32: data width.
- ADDR_W, 32: address width on all ports.

- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- pN_req  in  1  (N=0,1) request; held high with fields stable until pN_gnt.
- pN_we  in  1  1=write, 0=read.
- pN_addr  in  ADDR_W  word address.
- pN_wdata  in  DATA_W  write data.
- pN_gnt  out  1  one-cycle pulse: request accepted; requester may change fields next cycle.
- pN_done  out  1  one-cycle pulse: transaction complete.
- pN_err  out  1  valid with pN_done; 1 = address >= DEPTH, no memory access made.
- pN_rdata  out  DATA_W  read data, valid with pN_done on a good read; 0 otherwise.
- mem_we  out  1  to memory write_enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_rdata  in  DATA_W  from memory mem_read_data (valid the cycle after the address is clocked with mem_we=0).

## Operation
- FSM states: IDLE, ISSUE, RESP. All outputs registered.
- IDLE: if any req, choose winner, latch winner's we/addr/wdata and port id, go ISSUE. Else stay.
- Arbitration: round-robin on pointer last (port last granted). Both requesting -> grant port != last. One requesting -> grant it. Update last on every grant.
- ISSUE: gnt pulses to winner; mem_addr = latched addr; mem_we = latched we AND addr < DEPTH; mem_wdata = latched wdata. Next: read with legal address -> RESP; otherwise -> IDLE with done pulse next cycle.
- RESP: mem_we=0, mem_addr held; at the closing edge capture mem_rdata into pN_rdata; go IDLE, done pulse next cycle.
- Outside ISSUE, mem_we=0; mem_addr/mem_wdata hold last values.
- Out-of-range (addr >= DEPTH, unsigned compare on full ADDR_W): no write, done+err pulse, rdata=0.
- req is ignored in ISSUE/RESP; a requester still high after gnt at edge is not re-granted unless still high in a later IDLE cycle (requester must drop req the cycle after gnt).
- Only the granted port's gnt/done/err/rdata change; other port's outputs stay 0 (rdata holds 0).

## Timing
- Reset values: state IDLE, last=1 (port 0 wins first tie), mem_we=0, mem_addr=0, mem_wdata=0, all gnt/done/err=0, both rdata=0.
- Cycle 0 = IDLE cycle where req sampled. Cycle 1: gnt, memory op presented. Write/err: done in cycle 2. Good read: RESP in cycle 2, done+rdata in cycle 3.
- New arbitration happens in the same cycle a done pulse is output (done cycle is IDLE); max throughput: write every 2 cycles, read every 3.
- Simultaneous req from both ports in IDLE: one grant; loser's req remains pending and is granted in the next IDLE cycle.
- Reset asserted in any cycle: takes effect at that edge; an in-flight op already presented on mem pins in that cycle completes at memory, but no done/err is produced; all outputs take reset values next cycle.
- rdata holds until that port's next done.

## Test plan
- Write p1 addr=0x10 data=0xDEADBEEF, then read p0 addr=0x10 -> p1_done cycle 2 with err=0; p0_done cycle 3 with p0_rdata=0xDEADBEEF.
- Both ports req reads in same cycle after reset (addr 0x01, 0x02 preloaded 0x11/0x22) -> p0 granted first, p1 granted next IDLE; p0_rdata=0x11, p1_rdata=0x22; next tie goes to p0 again only after p1 won.
- p0 holds req continuously with p1 idle -> back-to-back reads every 3 cycles, no gap longer than 3.
- Write p1 addr=0x100 (DEPTH=256) -> mem_we stays 0, p1_done+p1_err cycle 2; read addr 0xFFFFFFFF -> done+err, rdata=0.
- Reset asserted during RESP of a read -> no p0_done, all outputs 0 next cycle, last=1, subsequent read works.
- Write addr=0xFF then read 0xFF -> boundary address legal, data returns, err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter and sequencer for a single-port synchronous data memory.
// Port 0 (fetch) and port 1 (load/store) issue read/write requests. The block
// grants one request at a time in round-robin order and drives the memory pins.
// It returns a done pulse, plus read data on a good read. Addresses at or above
// DEPTH are rejected: done and err pulse together and the memory is not touched.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   pN_req/we/addr/wdata   request from port N (held stable until pN_gnt)
//   pN_gnt                 one-cycle pulse, request accepted
//   pN_done/err            one-cycle pulse, transaction complete / bad address
//   pN_rdata               read data, updated only on that port's done
//   mem_we/addr/wdata      memory pins (this block is their only driver)
//   mem_rdata              memory read data, valid the cycle after a read
//                          address is clocked
//
// Per-transaction timeline (cycle 0 = IDLE cycle in which req is sampled):
//   cycle 1  ISSUE : gnt pulse, operation presented on the memory pins
//   cycle 2  write or bad address -> done (and err) while back in IDLE
//            good read           -> RESP, memory returns data
//   cycle 3  good read -> done + rdata while back in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Unsigned upper bound on the full address width, so that huge addresses
  // such as all-ones are rejected instead of wrapping into range.
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Round-robin pointer: the port granted most recently.
  logic last_q, last_d;

  // Transaction latched when it is granted.
  logic              op_port_q;
  logic              op_we_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic [DATA_W-1:0] op_wdata_q;
  logic              op_legal;

  // Registered outputs, indexed by port number.
  logic [1:0]             gnt_q,   gnt_d;
  logic [1:0]             done_q,  done_d;
  logic [1:0]             err_q,   err_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic                   mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration: on a tie the port that did not win last time goes first.
  // A lone requester wins regardless of the pointer.
  // ---------------------------------------------------------------------------
  logic              any_req;
  logic              win_port;
  logic              win_we;
  logic              win_legal;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign any_req   = p0_req | p1_req;
  assign win_port  = (p0_req && p1_req) ? ~last_q : p1_req;
  assign win_we    = win_port ? p1_we    : p0_we;
  assign win_addr  = win_port ? p1_addr  : p0_addr;
  assign win_wdata = win_port ? p1_wdata : p0_wdata;
  assign win_legal = (win_addr < DEPTH_LIM);

  assign op_legal  = (op_addr_q < DEPTH_LIM);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default on every path keeps this purely combinational; a branch
    // that left state_d unassigned would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      // Only a good read needs the extra cycle to collect memory data.
      ISSUE:   state_d = (!op_we_q && op_legal) ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs.
  // Everything is computed one cycle ahead so that gnt and the memory pins
  // appear in ISSUE, and done appears in the IDLE cycle that follows.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_d       = '0;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata_q;       // rdata holds until that port's next done
    mem_we_d    = 1'b0;          // write enable is only ever high in ISSUE
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    last_d      = last_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d[win_port] = 1'b1;
          last_d          = win_port;
          mem_addr_d      = win_addr;
          mem_wdata_d     = win_wdata;
          mem_we_d        = win_we & win_legal;
        end
      end
      ISSUE: begin
        // Writes and rejected accesses finish here; a good read goes to RESP.
        if (op_we_q || !op_legal) begin
          done_d[op_port_q]  = 1'b1;
          err_d[op_port_q]   = ~op_legal;
          rdata_d[op_port_q] = '0;
        end
      end
      RESP: begin
        done_d[op_port_q]  = 1'b1;
        rdata_d[op_port_q] = mem_rdata;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and transaction registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;       // port 0 wins the first tie after reset
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      op_port_q   <= 1'b0;
      op_we_q     <= 1'b0;
      op_addr_q   <= '0;
      op_wdata_q  <= '0;
    end else begin
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == IDLE && any_req) begin
        op_port_q  <= win_port;
        op_we_q    <= win_we;
        op_addr_q  <= win_addr;
        op_wdata_q <= win_wdata;
      end
    end
  end

  assign p0_gnt    = gnt_q[0];
  assign p0_done   = done_q[0];
  assign p0_err    = err_q[0];
  assign p0_rdata  = rdata_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p1_done   = done_q[1];
  assign p1_err    = err_q[1];
  assign p1_rdata  = rdata_q[1];
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
